// File: rtl/sdram_init_refresh_seq.sv
// rtl/sdram_init_refresh_seq.sv - SDRAM power-up init and auto-refresh sequencer
// Owns the PHY command bus during init and refresh; hands it to the scheduler via ref_req/ref_ack.
module sdram_init_refresh_seq #(
  parameter int W_BANKSEL      = 2,
  parameter int W_ADDR         = 13,
  parameter int W_DATA         = 16,
  parameter int T_POWERUP      = 20000,
  parameter int T_RP           = 3,
  parameter int T_RFC          = 9,
  parameter int T_MRD          = 2,
  parameter int INIT_REFRESHES = 8,
  parameter int T_REFI         = 780,
  parameter int MAX_OWED       = 8,
  parameter int CAS_LATENCY    = 2,
  parameter int BURST_LEN      = 8
) (
  input  logic                  clk_sys,
  input  logic                  rst_n_por,
  input  logic                  ref_ack,
  output logic                  bus_own,
  output logic                  ref_req,
  output logic                  init_done,
  output logic                  ref_overrun,
  output logic                  phy_clk_enable,
  output logic                  phy_clke_next,
  output logic                  phy_cs_n_next,
  output logic                  phy_ras_n_next,
  output logic                  phy_cas_n_next,
  output logic                  phy_we_n_next,
  output logic [W_BANKSEL-1:0]  phy_ba_next,
  output logic [W_ADDR-1:0]     phy_a_next,
  output logic [W_DATA/8-1:0]   phy_dqm_next
);

  localparam int W_CNT  = $clog2(T_POWERUP + T_RP + T_RFC + T_MRD + 1);
  localparam int W_REFI = $clog2(T_REFI + 1);
  localparam int W_OWED = $clog2(MAX_OWED + 1);
  localparam int W_NREF = $clog2(INIT_REFRESHES + 1);

  localparam logic [W_ADDR-1:0] MODE_WORD = W_ADDR'((CAS_LATENCY << 4) | $clog2(BURST_LEN));
  localparam logic [W_ADDR-1:0] A10_ALL   = W_ADDR'(1024);
  localparam logic [W_OWED-1:0] OWED_MAX  = W_OWED'(MAX_OWED);

  localparam logic [3:0] CMD_INH = 4'b1111;
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  typedef enum logic [2:0] {
    PWRUP, INIT_PRE, INIT_REF, INIT_MRS, IDLE, REF_PRE, REF_REF
  } state_t;

  state_t            state;
  logic [W_CNT-1:0]  wait_cnt;
  logic [W_REFI-1:0] refi_cnt;
  logic [W_OWED-1:0] owed;
  logic [W_NREF-1:0] init_refs;
  logic [3:0]        cmd;

  logic              debit, credit, grant, idle_next;
  logic [W_OWED-1:0] owed_next;

  assign {phy_cs_n_next, phy_ras_n_next, phy_cas_n_next, phy_we_n_next} = cmd;

  // ref_req is registered from the post-edge state/debt so it can rise on the debit or release edge
  always_comb begin
    debit     = init_done && (refi_cnt == '0);
    credit    = (state == REF_PRE) && (wait_cnt == '0) && (owed != '0);
    grant     = (state == IDLE) && ref_req && ref_ack;
    idle_next = ((state == IDLE) && !grant)
             || ((state == REF_REF) && (wait_cnt == '0))
             || ((state == INIT_MRS) && (wait_cnt == '0));
    owed_next = owed;
    if (debit && !credit && (owed != OWED_MAX)) owed_next = owed + 1'b1;
    else if (credit && !debit)                  owed_next = owed - 1'b1;
  end

  always_ff @(posedge clk_sys or negedge rst_n_por) begin
    if (!rst_n_por) begin
      state          <= PWRUP;
      wait_cnt       <= W_CNT'(T_POWERUP);
      refi_cnt       <= W_REFI'(T_REFI - 1);
      owed           <= '0;
      init_refs      <= '0;
      cmd            <= CMD_INH;
      phy_a_next     <= '0;
      phy_ba_next    <= '0;
      phy_dqm_next   <= '1;
      phy_clke_next  <= 1'b0;
      phy_clk_enable <= 1'b0;
      bus_own        <= 1'b1;
      ref_req        <= 1'b0;
      init_done      <= 1'b0;
      ref_overrun    <= 1'b0;
    end else begin
      phy_clke_next  <= 1'b1;
      phy_clk_enable <= 1'b1;
      owed           <= owed_next;
      ref_req        <= idle_next && (owed_next != '0);
      if (debit && (owed == OWED_MAX)) ref_overrun <= 1'b1;
      if (!init_done)          refi_cnt <= W_REFI'(T_REFI - 1);
      else if (refi_cnt == '0) refi_cnt <= W_REFI'(T_REFI - 1);
      else                     refi_cnt <= refi_cnt - 1'b1;

      cmd         <= CMD_NOP;
      phy_a_next  <= '0;
      phy_ba_next <= '0;
      if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;

      case (state)
        PWRUP: if (wait_cnt == '0) begin
          cmd        <= CMD_PRE;
          phy_a_next <= A10_ALL;
          wait_cnt   <= W_CNT'(T_RP - 1);
          state      <= INIT_PRE;
        end
        INIT_PRE: if (wait_cnt == '0) begin
          cmd       <= CMD_REF;
          wait_cnt  <= W_CNT'(T_RFC - 1);
          init_refs <= W_NREF'(1);
          state     <= INIT_REF;
        end
        INIT_REF: if (wait_cnt == '0) begin
          if (init_refs == W_NREF'(INIT_REFRESHES)) begin
            cmd        <= CMD_LMR;
            phy_a_next <= MODE_WORD;
            wait_cnt   <= W_CNT'(T_MRD - 1);
            state      <= INIT_MRS;
          end else begin
            cmd       <= CMD_REF;
            wait_cnt  <= W_CNT'(T_RFC - 1);
            init_refs <= init_refs + 1'b1;
          end
        end
        INIT_MRS: if (wait_cnt == '0) begin
          init_done    <= 1'b1;
          bus_own      <= 1'b0;
          phy_dqm_next <= '0;
          state        <= IDLE;
        end
        IDLE: if (grant) begin
          bus_own      <= 1'b1;
          phy_dqm_next <= '1;
          cmd          <= CMD_PRE;
          phy_a_next   <= A10_ALL;
          wait_cnt     <= W_CNT'(T_RP - 1);
          state        <= REF_PRE;
        end
        REF_PRE: if (wait_cnt == '0) begin
          cmd      <= CMD_REF;
          wait_cnt <= W_CNT'(T_RFC - 1);
          state    <= REF_REF;
        end
        REF_REF: if (wait_cnt == '0) begin
          bus_own      <= 1'b0;
          phy_dqm_next <= '0;
          state        <= IDLE;
        end
        default: state <= PWRUP;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_init_refresh_seq.sv
// tb/tb_sdram_init_refresh_seq.sv - self-checking bench for sdram_init_refresh_seq
// Timestamp-based reference model plus init table and hand-written handshake sequences.
module tb_sdram_init_refresh_seq;

  localparam int TP = 10, TRP = 2, TRFC = 4, TMRD = 2, NIR = 2, TREFI = 50, MAXO = 2;
  localparam int P = TP;
  localparam int M = TP + TRP + NIR * TRFC;
  localparam int INIT_END = M + TMRD;
  localparam logic [12:0] MODE = 13'((2 << 4) | 3);

  logic clk_sys = 1'b0;
  logic rst_n_por = 1'b0;
  logic ref_ack = 1'b0;
  logic bus_own, ref_req, init_done, ref_overrun, phy_clk_enable, phy_clke_next;
  logic phy_cs_n_next, phy_ras_n_next, phy_cas_n_next, phy_we_n_next;
  logic [1:0]  phy_ba_next;
  logic [12:0] phy_a_next;
  logic [1:0]  phy_dqm_next;

  always #5 clk_sys = ~clk_sys;

  sdram_init_refresh_seq #(
    .T_POWERUP(TP), .T_RP(TRP), .T_RFC(TRFC), .T_MRD(TMRD),
    .INIT_REFRESHES(NIR), .T_REFI(TREFI), .MAX_OWED(MAXO)
  ) dut (
    .clk_sys(clk_sys), .rst_n_por(rst_n_por), .ref_ack(ref_ack),
    .bus_own(bus_own), .ref_req(ref_req), .init_done(init_done), .ref_overrun(ref_overrun),
    .phy_clk_enable(phy_clk_enable), .phy_clke_next(phy_clke_next),
    .phy_cs_n_next(phy_cs_n_next), .phy_ras_n_next(phy_ras_n_next),
    .phy_cas_n_next(phy_cas_n_next), .phy_we_n_next(phy_we_n_next),
    .phy_ba_next(phy_ba_next), .phy_a_next(phy_a_next), .phy_dqm_next(phy_dqm_next)
  );

  typedef struct packed {
    logic        bus_own, ref_req, init_done, ref_overrun, clk_en, clke;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic [1:0]  dqm;
  } obs_t;

  typedef struct {
    int          c;
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic        own;
    logic        done;
  } vec_t;

  localparam obs_t RST_OBS = '{bus_own: 1'b1, ref_req: 1'b0, init_done: 1'b0, ref_overrun: 1'b0,
                               clk_en: 1'b0, clke: 1'b0, cmd: 4'hF, ba: 2'b0, addr: 13'h0, dqm: 2'b11};

  int   checks = 0, failures = 0, cyc = -1;
  int   m_owed, m_pre;
  bit   m_ovr, m_prev_idle, m_prev_req;
  obs_t act, expv;
  obs_t hist [0:31];
  vec_t tab  [11];

  function automatic obs_t sample();
    obs_t o;
    o.bus_own = bus_own; o.ref_req = ref_req; o.init_done = init_done; o.ref_overrun = ref_overrun;
    o.clk_en = phy_clk_enable; o.clke = phy_clke_next;
    o.cmd = {phy_cs_n_next, phy_ras_n_next, phy_cas_n_next, phy_we_n_next};
    o.ba = phy_ba_next; o.addr = phy_a_next; o.dqm = phy_dqm_next;
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t a_, input obs_t e_);
    checks++;
    if (a_ !== e_) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, a_, e_);
    end
  endtask

  task automatic check_val(input string name, input int a_, input int e_);
    checks++;
    if (a_ != e_) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, a_, e_);
    end
  endtask

  task automatic model_reset();
    m_owed = 0; m_pre = -1000; m_ovr = 0; m_prev_idle = 0; m_prev_req = 0; cyc = -1;
  endtask

  // Expected outputs for cycle c, from event timestamps and a debt integer
  task automatic model_cycle(input int c, input logic ack_in, output obs_t e);
    bit busy, debit, credit;
    e = '0; e.clk_en = 1'b1; e.clke = 1'b1; e.cmd = 4'b0111;
    if (c < INIT_END) begin
      e.bus_own = 1'b1; e.dqm = 2'b11;
      if (c == P) begin e.cmd = 4'b0010; e.addr = 13'h400; end
      else if (c == M) begin e.cmd = 4'b0000; e.addr = MODE; end
      else if (c >= P + TRP && c < M && (c - P - TRP) % TRFC == 0) e.cmd = 4'b0001;
      m_prev_idle = 0; m_prev_req = 0;
    end else begin
      if (m_prev_idle && m_prev_req && ack_in) m_pre = c;
      busy   = (c >= m_pre) && (c < m_pre + TRP + TRFC);
      credit = (c == m_pre + TRP);
      debit  = (c > INIT_END) && ((c - INIT_END) % TREFI == 0);
      if (busy) begin
        e.bus_own = 1'b1; e.dqm = 2'b11;
        if (c == m_pre) begin e.cmd = 4'b0010; e.addr = 13'h400; end
        if (credit) e.cmd = 4'b0001;
      end
      if (debit && m_owed == MAXO) m_ovr = 1;
      if (debit && !credit) m_owed = (m_owed < MAXO) ? m_owed + 1 : MAXO;
      else if (credit && !debit) m_owed = m_owed - 1;
      e.init_done = 1'b1;
      e.ref_overrun = m_ovr;
      e.ref_req = !busy && (m_owed != 0);
      m_prev_idle = !busy; m_prev_req = e.ref_req;
    end
  endtask

  task automatic step();
    logic ack_now;
    ack_now = ref_ack;
    @(posedge clk_sys); #1;
    cyc++;
    model_cycle(cyc, ack_now, expv);
    act = sample();
    if (cyc < 32) hist[cyc] = act;
    check_obs("model", act, expv);
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    rst_n_por = 1'b1;
    model_reset();
  endtask

  task automatic wait_req(input string name);
    int guard;
    guard = 0;
    while (!ref_req && guard < 200) begin step(); guard++; end
    check_val({name, "_req_seen"}, int'(ref_req), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1);
  end

  initial begin
    int a_cyc, init_pre, run_pre;
    logic [3:0] nop;
    nop = 4'b0111;
    tab[0]  = '{0,        nop,     13'h000, 1'b1, 1'b0};
    tab[1]  = '{P - 1,    nop,     13'h000, 1'b1, 1'b0};
    tab[2]  = '{P,        4'b0010, 13'h400, 1'b1, 1'b0};
    tab[3]  = '{P + 1,    nop,     13'h000, 1'b1, 1'b0};
    tab[4]  = '{12,       4'b0001, 13'h000, 1'b1, 1'b0};
    tab[5]  = '{14,       nop,     13'h000, 1'b1, 1'b0};
    tab[6]  = '{16,       4'b0001, 13'h000, 1'b1, 1'b0};
    tab[7]  = '{20,       4'b0000, 13'h023, 1'b1, 1'b0};
    tab[8]  = '{21,       nop,     13'h000, 1'b1, 1'b0};
    tab[9]  = '{22,       nop,     13'h000, 1'b0, 1'b1};
    tab[10] = '{23,       nop,     13'h000, 1'b0, 1'b1};

    repeat (3) @(posedge clk_sys); #1;
    check_obs("reset_state", sample(), RST_OBS);

    release_reset();
    repeat (INIT_END + 2) step();
    for (int i = 0; i < 11; i++) begin
      cyc = tab[i].c;
      check_val("init_cmd",  int'(hist[tab[i].c].cmd),       int'(tab[i].cmd));
      check_val("init_addr", int'(hist[tab[i].c].addr),      int'(tab[i].addr));
      check_val("init_own",  int'(hist[tab[i].c].bus_own),   int'(tab[i].own));
      check_val("init_done", int'(hist[tab[i].c].init_done), int'(tab[i].done));
      check_val("init_dqm",  int'(hist[tab[i].c].dqm),       tab[i].own ? 3 : 0);
    end
    cyc = INIT_END + 1;

    while (cyc < 71) step();
    check_val("first_debit_pre", int'(ref_req), 0);
    step();
    check_val("first_debit", int'(ref_req), 1);

    while (cyc < 79) step();
    a_cyc = cyc;
    ref_ack = 1'b1; step(); ref_ack = 1'b0;
    check_val("grant_pre", int'({phy_cs_n_next, phy_ras_n_next, phy_cas_n_next, phy_we_n_next}), 4'b0010);
    check_val("grant_req_drop", int'(ref_req), 0);
    while (cyc < a_cyc + 3) step();
    check_val("grant_ref", int'({phy_cs_n_next, phy_ras_n_next, phy_cas_n_next, phy_we_n_next}), 4'b0001);
    while (cyc < a_cyc + 6) step();
    check_val("grant_own_held", int'(bus_own), 1);
    step();
    check_val("grant_own_release", int'(bus_own), 0);
    check_val("grant_req_after", int'(ref_req), 0);

    while (cyc < 221) step();
    check_val("sat_ovr_before", int'(ref_overrun), 0);
    step();
    check_val("sat_ovr_after", int'(ref_overrun), 1);
    for (int r = 0; r < 2; r++) begin
      wait_req("sat");
      ref_ack = 1'b1; step(); ref_ack = 1'b0;
      check_val("sat_pre", int'({phy_cs_n_next, phy_ras_n_next, phy_cas_n_next, phy_we_n_next}), 4'b0010);
      repeat (TRP + TRFC) step();
    end
    check_val("sat_req_clear", int'(ref_req), 0);
    check_val("sat_ovr_sticky", int'(ref_overrun), 1);

    repeat (1200) begin
      ref_ack = ($urandom_range(0, 3) == 0);
      step();
    end
    ref_ack = 1'b0;

    rst_n_por = 1'b0; #1;
    check_obs("reset_from_random", sample(), RST_OBS);
    ref_ack = 1'b1;
    release_reset();
    init_pre = 0; run_pre = 0;
    while (cyc < 230) begin
      step();
      if (act.cmd == 4'b0010) begin
        if (cyc < INIT_END) init_pre++;
        else run_pre++;
      end
    end
    ref_ack = 1'b0;
    check_val("ack_held_init_pre", init_pre, 1);
    check_val("ack_held_refreshes", run_pre, 4);

    wait_req("midrst");
    ref_ack = 1'b1; step(); ref_ack = 1'b0;
    step();
    rst_n_por = 1'b0; #1;
    check_obs("mid_refresh_reset", sample(), RST_OBS);
    release_reset();
    while (cyc < P) step();
    check_val("midrst_pre", int'({phy_cs_n_next, phy_ras_n_next, phy_cas_n_next, phy_we_n_next}), 4'b0010);
    while (cyc < INIT_END + 1) step();
    check_val("midrst_owed_zero", int'(ref_req), 0);
    check_val("midrst_ovr_clear", int'(ref_overrun), 0);
    while (cyc < 75) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_init_refresh_seq.md
Name: sdram_init_refresh_seq

Overview:
- Owns the SDRAM command bus during power-up initialisation and periodic auto-refresh.
- Shares the bus with the read/write scheduler through a req/ack handshake.
- Output drives the *_next PHY command signals via a 2:1 mux selected by bus_own.
- Computes the mode-register word from parameters, so the init sequence and refresh debt tracking live in one place.

Parameters:
W_BANKSEL, 2, bank-select width
W_ADDR, 13, address bus width
W_DATA, 16, DQ width (DQM width = W_DATA/8)
T_POWERUP, 20000, NOP cycles after reset before first PRECHARGE ALL
T_RP, 3, cycles from PRECHARGE to next command
T_RFC, 9, cycles from AUTO REFRESH to next command
T_MRD, 2, cycles from LOAD MODE to init_done
INIT_REFRESHES, 8, auto-refreshes during init (>=1)
T_REFI, 780, cycles between refresh debits
MAX_OWED, 8, refresh debt saturation limit
CAS_LATENCY, 2, mode register CL (2 or 3)
BURST_LEN, 8, mode register burst length (1,2,4,8)

Ports:
clk_sys  in  1  system clock
rst_n_por  in  1  reset, asynchronous, active-low
ref_ack  in  1  scheduler: banks quiescent, no command this cycle, bus yielded
bus_own  out  1  1 = this block's command outputs select the PHY mux
ref_req  out  1  refresh owed; scheduler should yield
init_done  out  1  init complete, sticky until reset
ref_overrun  out  1  sticky: debt hit MAX_OWED and another debit arrived
phy_clk_enable  out  1  SDRAM clock enable to PHY
phy_clke_next  out  1  CKE
phy_cs_n_next, phy_ras_n_next, phy_cas_n_next, phy_we_n_next  out  1 each  command
phy_ba_next  out  W_BANKSEL  bank
phy_a_next  out  W_ADDR  address/opcode
phy_dqm_next  out  W_DATA/8  byte masks

Behaviour:
- Reset is rst_n_por, asynchronous, active-low; clock is clk_sys. All outputs registered.
- Reset values:
  - cs_n=ras_n=cas_n=we_n=1; a=0; ba=0; dqm=all ones.
  - clke=0; phy_clk_enable=0; bus_own=1.
  - ref_req=0; init_done=0; ref_overrun=0; owed=0.
- Cycle 0 is the first rising edge after reset release. From cycle 0: clke=1 and phy_clk_enable=1 permanently.
- Command encodings (cs,ras,cas,we), each driven for exactly one cycle:
  - NOP = 0111
  - PRECHARGE ALL = 0010 with a[10]=1, other a bits 0
  - AUTO REFRESH = 0001
  - LOAD MODE = 0000 with ba=0, a = {0.., A[6:4]=CL, A3=0 sequential, A[2:0]=log2(BURST_LEN)}; BL8/CL2 gives 0x023.
  - All other owned cycles: NOP.
- dqm is all ones whenever bus_own=1.
- FSM states: PWRUP, INIT_PRE, INIT_REF, INIT_MRS, IDLE, REF_PRE, REF_REF.
- Init timeline:
  - PWRUP: NOP for cycles 0..T_POWERUP-1.
  - PRECHARGE at cycle P = T_POWERUP.
  - AUTO REFRESH at P+T_RP+k*T_RFC, for k = 0..INIT_REFRESHES-1.
  - LOAD MODE at M = P+T_RP+INIT_REFRESHES*T_RFC.
  - At M+T_MRD: init_done=1, bus_own=0, enter IDLE.
- Refresh interval counter:
  - Loads T_REFI-1 on entering IDLE from init, then free-runs in all later states.
  - At 0: reload and debit (owed+1).
  - A debit while owed==MAX_OWED leaves owed at MAX_OWED and sets ref_overrun.
- Debit and credit in the same cycle leave owed unchanged.
- ref_req = registered (state==IDLE && owed!=0).
- Refresh handshake:
  - ref_ack is sampled only in IDLE with ref_req=1; it is ignored in all other cycles.
  - Ack at cycle A: at A+1, bus_own=1, ref_req=0, PRECHARGE ALL.
  - At A+1+T_RP: AUTO REFRESH, and owed is credited (owed-1).
  - At A+1+T_RP+T_RFC: bus_own=0, state IDLE; ref_req may reassert the same cycle if owed!=0.
- One refresh is performed per ack.
- When bus_own=0, command outputs hold NOP, dqm=0, a=0, ba=0.
- Reset asserted mid-sequence: immediate return to reset values; the full power-up wait is repeated, and owed and ref_overrun are cleared.

Test Plan:
Bench params for all scenarios: T_POWERUP=10, T_RP=2, T_RFC=4, T_MRD=2, INIT_REFRESHES=2, T_REFI=50, MAX_OWED=2.
- Init:
  - Release reset → PRECHARGE with a=0x400 at cycle 10; AUTO REFRESH at 12 and 16; LOAD MODE a=0x023 ba=0 at 20.
  - init_done=1 and bus_own=0 at 22; NOP and dqm=3 on every other owned cycle.
- First debit: no ack → ref_req rises at cycle 23+49 (counter expiry 71, registered 72), owed=1.
- Refresh grant: pulse ref_ack at cycle A with ref_req=1 → PRECHARGE at A+1, AUTO REFRESH at A+3, bus_own falls at A+7, ref_req=0 afterwards.
- Saturation: withhold ack for 3 intervals → owed=2, ref_overrun=1 after third expiry; two acks → two refresh sequences, then ref_req=0 while ref_overrun stays 1.
- Ack outside IDLE: ref_ack held high continuously → exactly one refresh per IDLE entry with owed>0, none during init.
- Mid-refresh reset: assert rst_n_por=0 at A+2 → outputs at reset values immediately; after release, PRECHARGE reappears at cycle 10 and owed=0.
